// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU/multiply, HI/LO register pair, and an
// iterative restoring divider that holds the pipeline while it runs.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int OP_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [OP_W-1:0]   ex_alu_op,
  input  logic [DATA_W-1:0] ex_reg_data_1,
  input  logic [DATA_W-1:0] ex_reg_data_2,
  input  logic [ADDR_W-1:0] ex_reg_write_addr,
  input  logic              ex_reg_write_en,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              wb_en,
  output logic              stall_req,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [OP_W-1:0] OP_AND   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(2);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_NOR   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_MULT  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_MULTU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_DIV   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_MTHI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_MTLO  = OP_W'(19);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

  div_state_t state, state_nxt;

  logic [DATA_W-1:0]        hi, lo;
  logic [4:0]               cnt;
  logic [DATA_W-1:0]        quo, rem, dvs;
  logic                     neg_q, neg_r;
  logic                     stall_int;
  logic                     is_div, is_signed_div;
  logic [DATA_W-1:0]        result;
  logic [4:0]               shamt;
  logic signed [DATA_W-1:0] a_s, b_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]      prod_u;
  logic [DATA_W:0]          rem_sh, diff;

  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v, input logic sgn);
    abs_val = (sgn && v[DATA_W-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v, input logic neg);
    cond_neg = neg ? (~v + 1'b1) : v;
  endfunction

  assign a_s    = ex_reg_data_1;
  assign b_s    = ex_reg_data_2;
  assign shamt  = ex_reg_data_1[4:0];
  assign prod_s = (2*DATA_W)'(a_s) * (2*DATA_W)'(b_s);
  assign prod_u = (2*DATA_W)'(ex_reg_data_1) * (2*DATA_W)'(ex_reg_data_2);

  assign is_div        = (ex_alu_op == OP_DIV) || (ex_alu_op == OP_DIVU);
  assign is_signed_div = (ex_alu_op == OP_DIV);

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign rem_sh = {rem, quo[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_comb begin
    result = '0;
    case (ex_alu_op)
      OP_AND:  result = ex_reg_data_1 & ex_reg_data_2;
      OP_OR:   result = ex_reg_data_1 | ex_reg_data_2;
      OP_XOR:  result = ex_reg_data_1 ^ ex_reg_data_2;
      OP_NOR:  result = ~(ex_reg_data_1 | ex_reg_data_2);
      OP_SLL:  result = ex_reg_data_2 << shamt;
      OP_SRL:  result = ex_reg_data_2 >> shamt;
      OP_SRA:  result = DATA_W'(b_s >>> shamt);
      OP_ADD:  result = ex_reg_data_1 + ex_reg_data_2;
      OP_SUB:  result = ex_reg_data_1 - ex_reg_data_2;
      OP_SLT:  result = DATA_W'(a_s < b_s);
      OP_SLTU: result = DATA_W'(ex_reg_data_1 < ex_reg_data_2);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  always_comb begin
    stall_int = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        stall_int = is_div;
        if (is_div) state_nxt = (ex_reg_data_2 == '0) ? DONE : BUSY;
      end
      BUSY: begin
        stall_int = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  assign stall_req = rst & ~flush & stall_int;
  assign wb_data   = rst ? result : '0;
  assign wb_addr   = rst ? ex_reg_write_addr : '0;
  assign wb_en     = rst & ex_reg_write_en & ~flush & ~stall_req;
  assign hi_o      = hi;
  assign lo_o      = lo;

  // Control state: divider FSM and iteration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == BUSY) cnt <= cnt + 5'd1;
      else               cnt <= '0;
    end
  end

  // Divider datapath; no reset needed since IDLE always reloads it.
  always_ff @(posedge clk) begin
    if (state == IDLE && is_div && !flush) begin
      if (ex_reg_data_2 == '0) begin
        quo   <= '1;
        rem   <= ex_reg_data_1;
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else begin
        quo   <= abs_val(ex_reg_data_1, is_signed_div);
        dvs   <= abs_val(ex_reg_data_2, is_signed_div);
        rem   <= '0;
        neg_q <= is_signed_div & (ex_reg_data_1[DATA_W-1] ^ ex_reg_data_2[DATA_W-1]);
        neg_r <= is_signed_div & ex_reg_data_1[DATA_W-1];
      end
    end else if (state == BUSY) begin
      if (!diff[DATA_W]) begin
        rem <= diff[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b1};
      end else begin
        rem <= rem_sh[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], 1'b0};
      end
    end
  end

  // HI/LO architectural state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush && !stall_req) begin
      if (state == DONE) begin
        lo <= cond_neg(quo, neg_q);
        hi <= cond_neg(rem, neg_r);
      end else begin
        case (ex_alu_op)
          OP_MULT:  {hi, lo} <= prod_s;
          OP_MULTU: {hi, lo} <= prod_u;
          OP_MTHI:  hi <= ex_reg_data_1;
          OP_MTLO:  lo <= ex_reg_data_1;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: ALU ops, HI/LO via multiply/move,
// iterative divide timing, flush and reset behaviour.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [4:0]  op;
  logic [31:0] d1, d2;
  logic [4:0]  waddr;
  logic        wen;
  logic [31:0] wb_data, hi_o, lo_o;
  logic [4:0]  wb_addr;
  logic        wb_en, stall_req;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_alu_op(op), .ex_reg_data_1(d1), .ex_reg_data_2(d2),
    .ex_reg_write_addr(waddr), .ex_reg_write_en(wen),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_en(wb_en),
    .stall_req(stall_req), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic we, input logic [4:0] ad, input logic fl);
    op = o; d1 = a; d2 = b; wen = we; waddr = ad; flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the first cycle with stall_req low (bounded).
  task automatic div_wait(output int n);
    n = 0;
    @(negedge clk);
    while (stall_req === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(5'd18, 32'hAAAA, 32'h0, 1'b1, 5'd7, 1'b0);
    @(negedge clk);
    total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", wb_data); end
    total++; if (wb_addr !== 5'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", wb_addr); end
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL rst_en got=%b exp=0", wb_en); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b exp=0", stall_req); end
    next_cycle();
    total++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin bad++; $display("FAIL rst_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
    drive(5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic test_alu();
    logic [4:0]  t_op [16] = '{5'd8, 5'd7, 5'd10, 5'd11, 5'd9, 5'd1, 5'd2, 5'd3,
                               5'd4, 5'd5, 5'd6, 5'd7, 5'd25, 5'd0, 5'd10, 5'd11};
    logic [31:0] t_a [16] = '{32'h7FFFFFFF, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5,
                              32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0, 32'd8,
                              32'h3F, 32'hFF, 32'd1, 32'd1, 32'd1, 32'd1};
    logic [31:0] t_b [16] = '{32'd1, 32'h80000000, 32'd1, 32'd1, 32'd7, 32'hFF00FF00,
                              32'h0F0F0000, 32'h0FF00FF0, 32'h0F0F0F0F, 32'd1, 32'h80000000,
                              32'h80000000, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] t_e [16] = '{32'h80000000, 32'hF8000000, 32'd1, 32'd0, 32'hFFFFFFFE,
                              32'hF000F000, 32'hFFFFF0F0, 32'hF00F0FF0, 32'hF0F0F0F0,
                              32'h100, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd0, 32'd1};
    logic [31:0] e;
    for (int i = 0; i < 16; i++) begin
      drive(t_op[i], t_a[i], t_b[i], 1'b1, 5'(i + 3), 1'b0);
      exp_q.push_back(t_e[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      total++; if (wb_data !== e) begin bad++; $display("FAIL alu_data[%0d] got=%h exp=%h", i, wb_data, e); end
      total++; if (wb_en !== 1'b1 || wb_addr !== 5'(i + 3))
        begin bad++; $display("FAIL alu_wb[%0d] got en=%b addr=%0d exp en=1 addr=%0d", i, wb_en, wb_addr, i + 3); end
      next_cycle();
    end
  endtask

  task automatic test_mult();
    logic [31:0] e;
    drive(5'd12, 32'hFFFFFFFF, 32'd2, 1'b1, 5'd1, 1'b0);
    exp_q.push_back(32'hFFFFFFFF); exp_q.push_back(32'hFFFFFFFE);
    @(negedge clk);
    total++; if (wb_data !== 32'h0) begin bad++; $display("FAIL mult_data got=%h exp=0", wb_data); end
    next_cycle();
    drive(5'd16, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    total++; if (wb_data !== e) begin bad++; $display("FAIL mult_mfhi got=%h exp=%h", wb_data, e); end
    next_cycle();
    drive(5'd17, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    total++; if (wb_data !== e) begin bad++; $display("FAIL mult_mflo got=%h exp=%h", wb_data, e); end
    next_cycle();
    drive(5'd13, 32'hFFFFFFFF, 32'd2, 1'b1, 5'd1, 1'b0);
    exp_q.push_back(32'h1);
    next_cycle();
    drive(5'd16, 32'h0, 32'h0, 1'b1, 5'd2, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    total++; if (wb_data !== e) begin bad++; $display("FAIL multu_mfhi got=%h exp=%h", wb_data, e); end
    total++; if (lo_o !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_lo got=%h exp=fffffffe", lo_o); end
    next_cycle();
  endtask

  task automatic test_div();
    int n;
    logic [31:0] eq, er;
    drive(5'd14, 32'hFFFFFFF9, 32'd2, 1'b1, 5'd4, 1'b0);
    exp_q.push_back(32'hFFFFFFFD); exp_q.push_back(32'hFFFFFFFF);
    div_wait(n);
    total++; if (n !== 33) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=33", n); end
    total++; if (wb_en !== 1'b1) begin bad++; $display("FAIL div_done_en got=%b exp=1", wb_en); end
    next_cycle();
    eq = exp_q.pop_front(); er = exp_q.pop_front();
    drive(5'd17, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    total++; if (wb_data !== eq) begin bad++; $display("FAIL div_mflo got=%h exp=%h", wb_data, eq); end
    next_cycle();
    drive(5'd16, 32'h0, 32'h0, 1'b1, 5'd5, 1'b0);
    @(negedge clk);
    total++; if (wb_data !== er) begin bad++; $display("FAIL div_mfhi got=%h exp=%h", wb_data, er); end
    next_cycle();
    drive(5'd15, 32'd100, 32'd7, 1'b1, 5'd6, 1'b0);
    exp_q.push_back(32'd14); exp_q.push_back(32'd2);
    div_wait(n);
    total++; if (n !== 33) begin bad++; $display("FAIL divu_stall_cycles got=%0d exp=33", n); end
    next_cycle();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    eq = exp_q.pop_front(); er = exp_q.pop_front();
    total++; if (lo_o !== eq || hi_o !== er) begin bad++; $display("FAIL divu_hilo got=%h/%h exp=%h/%h", lo_o, hi_o, eq, er); end
  endtask

  task automatic test_div_zero();
    int n;
    drive(5'd15, 32'd5, 32'd0, 1'b1, 5'd6, 1'b0);
    div_wait(n);
    total++; if (n !== 1) begin bad++; $display("FAIL divz_stall_cycles got=%0d exp=1", n); end
    next_cycle();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    total++; if (lo_o !== 32'hFFFFFFFF || hi_o !== 32'd5) begin bad++; $display("FAIL divz_hilo got=%h/%h exp=ffffffff/5", lo_o, hi_o); end
  endtask

  task automatic test_flush_div();
    drive(5'd14, 32'd100, 32'd7, 1'b1, 5'd8, 1'b0);
    repeat (10) next_cycle();
    total++; if (stall_req !== 1'b1) begin bad++; $display("FAIL flush_busy_stall got=%b exp=1", stall_req); end
    flush = 1'b1;
    #1;
    total++; if (stall_req !== 1'b0 || wb_en !== 1'b0) begin bad++; $display("FAIL flush_comb got stall=%b en=%b exp 0/0", stall_req, wb_en); end
    next_cycle();
    drive(5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b exp=0", stall_req); end
    repeat (40) next_cycle();
    total++; if (lo_o !== 32'hFFFFFFFF || hi_o !== 32'd5) begin bad++; $display("FAIL flush_hilo got=%h/%h exp=ffffffff/5", lo_o, hi_o); end
  endtask

  task automatic test_reset_mid_div();
    drive(5'd14, 32'hFFFFFFF9, 32'd2, 1'b1, 5'd9, 1'b0);
    repeat (5) next_cycle();
    rst = 1'b0;
    #1;
    total++; if (wb_data !== 32'h0 || wb_addr !== 5'h0 || wb_en !== 1'b0 || stall_req !== 1'b0)
      begin bad++; $display("FAIL rstmid_out got data=%h addr=%h en=%b stall=%b exp all 0", wb_data, wb_addr, wb_en, stall_req); end
    total++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin bad++; $display("FAIL rstmid_hilo got=%h/%h exp=0/0", hi_o, lo_o); end
    drive(5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%b exp=0", stall_req); end
    next_cycle();
  endtask

  task automatic test_mt_flush();
    drive(5'd18, 32'h1234, 32'h0, 1'b1, 5'd10, 1'b1);
    @(negedge clk);
    total++; if (wb_en !== 1'b0) begin bad++; $display("FAIL mt_flush_en got=%b exp=0", wb_en); end
    next_cycle();
    total++; if (hi_o !== 32'h0) begin bad++; $display("FAIL mt_flush_hi got=%h exp=0", hi_o); end
    drive(5'd18, 32'h1234, 32'h0, 1'b1, 5'd10, 1'b0);
    next_cycle();
    total++; if (hi_o !== 32'h1234) begin bad++; $display("FAIL mthi got=%h exp=1234", hi_o); end
    drive(5'd8, 32'd1, 32'd2, 1'b1, 5'd11, 1'b1);
    @(negedge clk);
    total++; if (wb_en !== 1'b0 || wb_data !== 32'd3) begin bad++; $display("FAIL add_flush got en=%b data=%h exp 0/3", wb_en, wb_data); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    drive(5'd12, 32'd3, 32'hFFFFFFFC, 1'b1, 5'd12, 1'b0);
    exp_q.push_back(32'hFFFFFFF4);
    next_cycle();
    drive(5'd17, 32'h0, 32'h0, 1'b1, 5'd12, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    total++; if (wb_data !== e) begin bad++; $display("FAIL b2b_mflo got=%h exp=%h", wb_data, e); end
    total++; if (hi_o !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_hi got=%h exp=ffffffff", hi_o); end
    next_cycle();
    drive(5'd19, 32'hCAFE0001, 32'h0, 1'b0, 5'd0, 1'b0);
    exp_q.push_back(32'hCAFE0001);
    next_cycle();
    drive(5'd17, 32'h0, 32'h0, 1'b1, 5'd13, 1'b0);
    @(negedge clk); e = exp_q.pop_front();
    total++; if (wb_data !== e) begin bad++; $display("FAIL b2b_mtlo got=%h exp=%h", wb_data, e); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    next_cycle();
    test_alu();
    test_mult();
    test_div();
    test_div_zero();
    test_flush_div();
    test_reset_mid_div();
    test_mt_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage core. It consumes the ID/EX pipeline-register outputs and computes the writeback value.
- Logic, shift, add/sub and compare ops complete in one cycle.
- Multiply completes in one cycle and writes HI/LO.
- Divide uses an iterative 32-step FSM and stalls the pipeline while it runs.
- Results feed the EX/MEM register combinationally. HI/LO are held inside this block.

Parameters:
DATA_W, 32, operand/result width (the divider is 32 iterations, so only 32 is supported)
ADDR_W, 5, register address width
OP_W, 5, ALU opcode width

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  annuls the current EX instruction (exception/branch flush)
ex_alu_op  in  5  opcode, encoding below
ex_reg_data_1  in  32  operand 1 (rs)
ex_reg_data_2  in  32  operand 2 (rt)
ex_reg_write_addr  in  5  destination register
ex_reg_write_en  in  1  destination write request
wb_data  out  32  result to EX/MEM
wb_addr  out  5  destination register, passed through
wb_en  out  1  qualified write enable
stall_req  out  1  high while the divider needs upstream held
hi_o  out  32  current HI register
lo_o  out  32  current LO register

Behaviour:
- Opcode encoding: 0 NOP, 1 AND, 2 OR, 3 XOR, 4 NOR, 5 SLL, 6 SRL, 7 SRA, 8 ADD, 9 SUB, 10 SLT, 11 SLTU, 12 MULT, 13 MULTU, 14 DIV, 15 DIVU, 16 MFHI, 17 MFLO, 18 MTHI, 19 MTLO. Values 20-31 behave as NOP.
- Reset (rst=0, async): HI=0, LO=0, FSM=IDLE. While rst=0, wb_data=0, wb_addr=0, wb_en=0, stall_req=0.
- Combinational result ops, same cycle:
  - Shift ops: amount = data_1[4:0], value = data_2; SRA is arithmetic.
  - ADD/SUB wrap modulo 2^32 with no overflow trap.
  - SLT is a signed compare, SLTU unsigned; result is 1 or 0.
  - MFHI/MFLO return the current HI/LO.
  - NOP, MULT*, DIV*, MT* return wb_data=0.
- Write enable: wb_en = ex_reg_write_en & ~flush & ~stall_req. wb_addr = ex_reg_write_addr always.
- MULT/MULTU: 64-bit signed/unsigned product; {HI,LO} is written at the next rising edge.
- MTHI/MTLO: data_1 is written to HI/LO at the next edge.
- A HI/LO write occurs only when flush=0 and stall_req=0.
- Divider FSM has three states: IDLE, BUSY, DONE.
  - IDLE, DIV/DIVU, flush=0, divisor!=0: latch operand magnitudes (absolute values for DIV) and sign flags; stall_req=1; next state BUSY, counter=0.
  - IDLE, divisor==0: stall_req=1; next state DONE with quotient=32'hFFFFFFFF, remainder=dividend (raw data_1).
  - BUSY: one restoring shift-subtract step per cycle; stall_req=1. After 32 cycles (counter==31), next state DONE.
  - DONE: stall_req=0. At this edge, LO=quotient and HI=remainder with signs fixed: quotient negated if operand signs differ (DIV only); remainder takes the dividend sign. Next state IDLE. DONE never restarts a divide.
  - Latency: op seen in cycle 0 → stall_req high cycles 0-32 → DONE in cycle 33 → HI/LO visible in cycle 34.
- Divide by zero: stall_req is high for 1 cycle only (cycle 0), and DONE occurs in cycle 1.
- flush in any state: the FSM returns to IDLE at the next edge with no HI/LO write. stall_req is forced to 0 combinationally while flush=1.
- Reset mid-divide: aborts immediately; HI/LO are cleared.
- Upstream contract: ID/EX holds its outputs stable while stall_req=1.

Test Plan:
- ADD 0x7FFFFFFF+1 with write_en=1, addr=3 → wb_data=0x80000000, wb_en=1, wb_addr=3. SRA 0x80000000 by 4 → 0xF8000000. SLT -1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
- MULT 0xFFFFFFFF×2 (signed), then MFHI → 0xFFFFFFFF; MFLO → 0xFFFFFFFE. The same operands as MULTU, then MFHI → 0x00000001.
- DIV -7/2 held stable → stall_req high for exactly 33 cycles, low in cycle 33. Then MFLO → 0xFFFFFFFD (-3) and MFHI → 0xFFFFFFFF (-1). DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → stall_req high 1 cycle; LO=0xFFFFFFFF, HI=5.
- DIV started, flush asserted in BUSY cycle 10 → stall_req=0 immediately, FSM idle next cycle, HI/LO unchanged. Also rst pulsed low mid-divide → outputs 0 asynchronously, HI=LO=0.
- MTHI 0x1234 with flush=1 → HI unchanged. With flush=0 → hi_o=0x1234 next cycle; an ADD with flush=1 gives wb_en=0.
